// File: rtl/axrd_outstanding.sv
`default_nettype none
// ============================================================================
// Module  : axrd_outstanding
// Brief   : AXI read-address issue stage. Buffers partitioned read commands
//           in a small FIFO and issues them on the AR channel while capping
//           the number of bursts that are issued but not yet retired by an
//           R-channel rlast beat.
// Revision: 1.0 - initial release
// ============================================================================
module axrd_outstanding #(
    parameter int AXI_AW     = 32,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_BURSTW = 2,
    parameter int AMI_AD     = 4,
    parameter int AMI_OD     = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    // command input from the burst partitioner
    input  logic [AXI_IW-1:0]            s_axid,
    input  logic [AXI_AW-1:0]            s_axaddr,
    input  logic [AXI_LW-1:0]            s_axlen,
    input  logic [AXI_SW-1:0]            s_axsize,
    input  logic [AXI_BURSTW-1:0]        s_axburst,
    input  logic                         s_axvalid,
    output logic                         s_axready,
    // AXI AR channel
    output logic [AXI_IW-1:0]            arid,
    output logic [AXI_AW-1:0]            araddr,
    output logic [AXI_LW-1:0]            arlen,
    output logic [AXI_SW-1:0]            arsize,
    output logic [AXI_BURSTW-1:0]        arburst,
    output logic                         arvalid,
    input  logic                         arready,
    // monitored R channel
    input  logic                         rvalid,
    input  logic                         rready,
    input  logic                         rlast,
    // status
    output logic [$clog2(AMI_OD+1)-1:0]  outst_cnt,
    output logic                         idle,
    output logic                         err_rlast
);

    localparam int C_PW = $clog2(AMI_AD);
    localparam int C_CW = $clog2(AMI_OD + 1);
    localparam logic [C_CW-1:0] C_OD     = C_CW'(AMI_OD);
    localparam logic [C_CW-1:0] C_CNT1   = C_CW'(1);
    localparam logic [C_PW:0]   C_PTR1   = (C_PW + 1)'(1);

    typedef struct packed {
        logic [AXI_IW-1:0]     id;
        logic [AXI_AW-1:0]     addr;
        logic [AXI_LW-1:0]     len;
        logic [AXI_SW-1:0]     size;
        logic [AXI_BURSTW-1:0] burst;
    } cmd_t;

    cmd_t              mem_q [AMI_AD];
    logic [C_PW:0]     wr_ptr_q, wr_ptr_d;
    logic [C_PW:0]     rd_ptr_q, rd_ptr_d;
    logic [C_CW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              w_full, w_empty;
    logic              w_push, w_pop, w_rbeat_last, w_retire;
    cmd_t              w_cmd_in, w_head;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_full  = (wr_ptr_q[C_PW] != rd_ptr_q[C_PW]) &&
                     (wr_ptr_q[C_PW-1:0] == rd_ptr_q[C_PW-1:0]);
    assign w_empty = (wr_ptr_q == rd_ptr_q);

    // Ready depends only on registered state: a pop never frees a slot early.
    assign s_axready    = !w_full;
    assign arvalid      = !w_empty && (cnt_q < C_OD);
    assign w_push       = s_axvalid && s_axready;
    assign w_pop        = arvalid && arready;
    assign w_rbeat_last = rvalid && rready && rlast;
    assign w_retire     = w_rbeat_last && (cnt_q != '0);

    assign w_cmd_in = '{id: s_axid, addr: s_axaddr, len: s_axlen,
                        size: s_axsize, burst: s_axburst};
    assign w_head   = mem_q[rd_ptr_q[C_PW-1:0]];

    // AR payload comes straight from head storage; no input-to-output path.
    assign arid    = w_head.id;
    assign araddr  = w_head.addr;
    assign arlen   = w_head.len;
    assign arsize  = w_head.size;
    assign arburst = w_head.burst;

    assign outst_cnt = cnt_q;
    assign err_rlast = err_q;
    assign idle      = w_empty && (cnt_q == '0);

    // Next-state for pointers, outstanding counter and sticky error flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (w_push) wr_ptr_d = wr_ptr_q + C_PTR1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + C_PTR1;
        if (w_pop && !w_retire)      cnt_d = cnt_q + C_CNT1;
        else if (!w_pop && w_retire) cnt_d = cnt_q - C_CNT1;
        // An rlast with nothing outstanding (and nothing issuing) is a protocol error.
        if (w_rbeat_last && (cnt_q == '0) && !w_pop) err_d = 1'b1;
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Command storage; cleared on reset so the AR payload reads back as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < AMI_AD; i++) mem_q[i] <= '0;
        end else if (w_push) begin
            mem_q[wr_ptr_q[C_PW-1:0]] <= w_cmd_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axrd_outstanding.sv
`default_nettype none
// ============================================================================
// Module  : tb_axrd_outstanding
// Brief   : Self-checking bench for axrd_outstanding. A queue-based model
//           tracks buffered commands, outstanding bursts and the error flag;
//           every cycle the DUT outputs are compared against it.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axrd_outstanding;

    localparam int AW = 32, IW = 8, LW = 8, SW = 3, BW = 2;
    localparam int AD = 4, OD = 4;
    localparam int CW = $clog2(OD + 1);

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [SW-1:0] size;
        logic [BW-1:0] burst;
    } cmd_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [IW-1:0] s_axid;
    logic [AW-1:0] s_axaddr;
    logic [LW-1:0] s_axlen;
    logic [SW-1:0] s_axsize;
    logic [BW-1:0] s_axburst;
    logic          s_axvalid, s_axready;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [LW-1:0] arlen;
    logic [SW-1:0] arsize;
    logic [BW-1:0] arburst;
    logic          arvalid, arready;
    logic          rvalid, rready, rlast;
    logic [CW-1:0] outst_cnt;
    logic          idle, err_rlast;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    cmd_t mq[$];
    int   mcnt;
    bit   merr;

    axrd_outstanding #(
        .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW), .AXI_BURSTW(BW),
        .AMI_AD(AD), .AMI_OD(OD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axid(s_axid), .s_axaddr(s_axaddr), .s_axlen(s_axlen),
        .s_axsize(s_axsize), .s_axburst(s_axburst),
        .s_axvalid(s_axvalid), .s_axready(s_axready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .outst_cnt(outst_cnt), .idle(idle), .err_rlast(err_rlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance on a clock edge, using the inputs the DUT sampled.
    task automatic model_step();
        bit   rdy, av, push, pop, rl, ret;
        cmd_t c;
        rdy  = mq.size() < AD;
        av   = (mq.size() != 0) && (mcnt < OD);
        push = s_axvalid && rdy;
        pop  = av && arready;
        rl   = rvalid && rready && rlast;
        ret  = rl && (mcnt != 0);
        if (rl && mcnt == 0 && !pop) merr = 1'b1;
        if (pop) begin
            void'(mq.pop_front());
            mcnt++;
        end
        if (ret) mcnt--;
        if (push) begin
            c = '{id: s_axid, addr: s_axaddr, len: s_axlen, size: s_axsize, burst: s_axburst};
            mq.push_back(c);
        end
    endtask

    // Compare all DUT outputs against the model.
    task automatic compare_model();
        bit av;
        av = (mq.size() != 0) && (mcnt < OD);
        chk("s_axready", s_axready, (mq.size() < AD));
        chk("arvalid",   arvalid,   av);
        chk("outst_cnt", outst_cnt, mcnt);
        chk("idle",      idle,      (mq.size() == 0) && (mcnt == 0));
        chk("err_rlast", err_rlast, merr);
        if (av && arvalid) begin
            chk("ar_payload", {arid, araddr, arlen, arsize, arburst}, mq[0]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic set_cmd(input bit v, input logic [AW-1:0] a, input logic [LW-1:0] l);
        s_axvalid = v;
        s_axaddr  = a;
        s_axlen   = l;
        s_axid    = a[IW-1:0];
        s_axsize  = 3'd2;
        s_axburst = 2'd1;
    endtask

    task automatic set_r(input bit b);
        rvalid = b;
        rready = b;
        rlast  = b;
    endtask

    // Assert reset mid-cycle, check outputs respond immediately, then release.
    task automatic async_reset(input bit lit);
        #3;
        reset_n = 1'b0;
        #1;
        mq.delete();
        mcnt = 0;
        merr = 1'b0;
        compare_model();
        if (lit) begin
            chk("rst_arvalid",   arvalid,   1'b0);
            chk("rst_outst_cnt", outst_cnt, 0);
            chk("rst_idle",      idle,      1'b1);
            chk("rst_s_axready", s_axready, 1'b1);
            chk("rst_err_rlast", err_rlast, 1'b0);
            chk("rst_araddr",    araddr,    0);
        end
        @(negedge clk);
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        set_cmd(1'b0, '0, '0);
        arready = 1'b0;
        set_r(1'b0);
        mcnt = 0;
        merr = 1'b0;

        // reset state
        #1;
        chk("reset_s_axready", s_axready, 1'b1);
        chk("reset_arvalid",   arvalid,   1'b0);
        chk("reset_idle",      idle,      1'b1);
        chk("reset_outst_cnt", outst_cnt, 0);
        chk("reset_araddr",    araddr,    0);
        @(negedge clk);
        cycle();
        reset_n = 1'b1;

        // single command, 1-cycle latency
        set_cmd(1'b1, 32'h100, 8'd15);
        arready = 1'b1;
        cycle();
        chk("first_arvalid", arvalid, 1'b1);
        chk("first_araddr",  araddr,  32'h100);
        chk("first_arlen",   arlen,   8'd15);
        chk("first_idle",    idle,    1'b0);
        set_cmd(1'b0, '0, '0);
        cycle();
        chk("first_outst", outst_cnt, 1);
        chk("first_arvalid_after", arvalid, 1'b0);
        set_r(1'b1);
        cycle();
        chk("first_retired_idle", idle, 1'b1);
        set_r(1'b0);

        // fill the buffer with AR stalled; 5th command must be held
        arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 32'h10 * (i + 1), 8'(i));
            cycle();
        end
        chk("full_s_axready", s_axready, 1'b0);
        set_cmd(1'b1, 32'h50, 8'd4);
        cycle();
        cycle();
        chk("held_s_axready", s_axready, 1'b0);
        chk("head_order", araddr, 32'h10);
        // release AR: pop does not pass ready through in the same cycle
        arready = 1'b1;
        cycle();
        chk("second_head", araddr, 32'h20);
        cycle();
        set_cmd(1'b0, '0, '0);
        for (int i = 0; i < 4; i++) cycle();
        chk("cap_outst", outst_cnt, 4);
        chk("cap_arvalid", arvalid, 1'b0);
        // one retire lets the 5th command issue
        arready = 1'b0;
        set_r(1'b1);
        cycle();
        chk("after_retire_arvalid", arvalid, 1'b1);
        chk("after_retire_araddr",  araddr,  32'h50);
        chk("after_retire_outst",   outst_cnt, 3);
        cycle();
        chk("outst_two", outst_cnt, 2);
        // simultaneous pop and retire
        arready = 1'b1;
        cycle();
        chk("pop_and_retire", outst_cnt, 2);
        arready = 1'b0;
        cycle();
        cycle();
        chk("drained", outst_cnt, 0);
        // unexpected rlast
        cycle();
        chk("err_set", err_rlast, 1'b1);
        chk("err_cnt_zero", outst_cnt, 0);
        set_r(1'b0);
        cycle();
        chk("err_sticky", err_rlast, 1'b1);

        // 3 buffered, 2 outstanding, then reset
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 32'hA0 + 32'(i), 8'(i));
            cycle();
        end
        set_cmd(1'b0, '0, '0);
        arready = 1'b1;
        cycle();
        cycle();
        arready = 1'b0;
        set_cmd(1'b1, 32'hB0, 8'd9);
        cycle();
        set_cmd(1'b0, '0, '0);
        chk("pre_rst_outst", outst_cnt, 2);
        async_reset(1'b1);
        cycle();
        chk("post_rst_arvalid", arvalid, 1'b0);

        // randomized traffic in phases of varying pressure
        for (int ph = 0; ph < 12; ph++) begin
            int pv, pa, pr;
            pv = $urandom_range(10, 95);
            pa = $urandom_range(10, 95);
            pr = $urandom_range(2, 50);
            for (int n = 0; n < 250; n++) begin
                s_axvalid = ($urandom_range(0, 99) < pv);
                s_axid    = IW'($urandom);
                s_axaddr  = $urandom;
                s_axlen   = LW'($urandom);
                s_axsize  = SW'($urandom);
                s_axburst = BW'($urandom);
                arready   = ($urandom_range(0, 99) < pa);
                rvalid    = ($urandom_range(0, 99) < pr + 20);
                rready    = ($urandom_range(0, 99) < 80);
                rlast     = ($urandom_range(0, 99) < pr);
                cycle();
            end
            if (ph % 4 == 3) async_reset(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
